// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned N_ROWS = 4;
    localparam int unsigned N_COLS = 4;

    typedef logic [BYTE_W-1:0] byte_t;
    // One state column, indexed by row.
    typedef byte_t [N_ROWS-1:0] column_t;
    // Full AES state, indexed [row][col].
    typedef byte_t [N_ROWS-1:0][N_COLS-1:0] state_t;

    localparam byte_t AES_POLY_REDUCE = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    // Multiply by x (i.e. by 2) modulo the AES polynomial.
    function automatic byte_t xtime(input byte_t b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_POLY_REDUCE : 8'h00);
    endfunction

    // Multiply by 3 = xtime(b) ^ b.
    function automatic byte_t gmul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns of one AES column.
//   col_i   : input column, col_i[r] is row r
//   mixed_c : transformed column, same row indexing
module mix_single_column
    import aes_pkg::*;
(
    input  column_t col_i,
    output column_t mixed_c
);

    byte_t a0, a1, a2, a3;

    assign a0 = col_i[0];
    assign a1 = col_i[1];
    assign a2 = col_i[2];
    assign a3 = col_i[3];

    // Circulant matrix {2,3,1,1} applied row by row.
    assign mixed_c[0] = xtime(a0) ^ gmul3(a1) ^ a2         ^ a3;
    assign mixed_c[1] = a0        ^ xtime(a1) ^ gmul3(a2)  ^ a3;
    assign mixed_c[2] = a0        ^ a1        ^ xtime(a2)  ^ gmul3(a3);
    assign mixed_c[3] = gmul3(a0) ^ a1        ^ a2         ^ xtime(a3);

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns stage, COLS_PER_CYCLE columns per clock.
//   clk, rst_n     : clock, async active-low reset
//   in_valid/ready : input handshake for din/in_last_round
//   din            : input state [row][col]
//   in_last_round  : 1 = final round, result is din unchanged
//   out_valid/ready: output handshake for dout
//   dout           : registered result state [row][col]
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t din,
    input  logic   in_last_round,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t dout
);

    localparam int unsigned COL_IDX_W  = 2;
    // A step of 4 wraps to 0, so the single-group case stays at column 0.
    localparam logic [COL_IDX_W-1:0] COL_STEP   = COL_IDX_W'(COLS_PER_CYCLE);
    localparam logic [COL_IDX_W-1:0] LAST_GROUP = COL_IDX_W'(N_COLS - COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_e              state_q, state_d;
    logic [COL_IDX_W-1:0]   col_idx_q, col_idx_d;
    state_t                 work_q, work_d;
    state_t                 dout_q, dout_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;

    column_t                grp_in  [COLS_PER_CYCLE];
    column_t                grp_out [COLS_PER_CYCLE];
    state_t                 busy_state;

    // Column group selected by col_idx feeds the mixer instances.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_grp
        for (genvar r = 0; r < N_ROWS; r++) begin : g_row
            assign grp_in[g][r] = work_q[r][col_idx_q + COL_IDX_W'(g)];
        end
        mix_single_column u_mix (
            .col_i   (grp_in[g]),
            .mixed_c (grp_out[g])
        );
    end

    // Working state with the current group's columns replaced. Group bases are
    // multiples of COLS_PER_CYCLE, so column c always comes from mixer c % N.
    for (genvar c = 0; c < N_COLS; c++) begin : g_wb
        localparam int unsigned MEMBER = c % COLS_PER_CYCLE;
        localparam logic [COL_IDX_W-1:0] BASE = COL_IDX_W'(c - MEMBER);
        for (genvar r = 0; r < N_ROWS; r++) begin : g_row
            assign busy_state[r][c] = (col_idx_q == BASE) ? grp_out[MEMBER][r] : work_q[r][c];
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        work_d      = work_q;
        dout_d      = dout_q;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d    = din;
                    col_idx_d = '0;
                    state_d   = in_last_round ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                work_d    = busy_state;
                col_idx_d = col_idx_q + COL_STEP;
                if (col_idx_q == LAST_GROUP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle loads the output register.
                out_valid_d = 1'b1;
                if (!out_valid_q) begin
                    dout_d = work_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_idx_q   <= '0;
            work_q      <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            work_q      <= work_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2 and 4 columns per cycle),
// scoreboard queue filled on accept and drained on output handshake.
`timescale 1ns/1ps
module tb_mix_columns_seq;
    import aes_pkg::*;

    localparam int unsigned N_DUT = 3;

    logic   clk;
    logic   rst_n_s     [N_DUT];
    logic   in_valid_s  [N_DUT];
    logic   in_ready_s  [N_DUT];
    logic   in_last_s   [N_DUT];
    logic   out_valid_s [N_DUT];
    logic   out_ready_s [N_DUT];
    state_t din_s       [N_DUT];
    state_t dout_s      [N_DUT];

    state_t exp_q [$];
    int     n_checks = 0;
    int     n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < N_DUT; i++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << i)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n_s[i]),
            .in_valid      (in_valid_s[i]),
            .in_ready      (in_ready_s[i]),
            .din           (din_s[i]),
            .in_last_round (in_last_s[i]),
            .out_valid     (out_valid_s[i]),
            .out_ready     (out_ready_s[i]),
            .dout          (dout_s[i])
        );
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p = '0;
        byte_t x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
        end
        return p;
    endfunction

    function automatic state_t ref_mix(input state_t s, input logic last);
        state_t res;
        byte_t  acc;
        byte_t  cf;
        int     k;
        if (last) return s;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    k  = (j - i + 4) % 4;
                    cf = (k == 0) ? 8'h02 : ((k == 1) ? 8'h03 : 8'h01);
                    acc = acc ^ gf_mul(s[2'(j)][2'(c)], cf);
                end
                res[2'(i)][2'(c)] = acc;
            end
        end
        return res;
    endfunction

    // Each word is one column, row 0 in the top byte.
    function automatic state_t mk_state(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
        state_t s;
        logic [3:0][31:0] w;
        w = {c3, c2, c1, c0};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[2'(r)][2'(c)] = 8'(w[2'(c)] >> (24 - 8 * r));
            end
        end
        return s;
    endfunction

    function automatic state_t rnd_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one block, push its expectation and measure accept-to-valid latency.
    task automatic send_block(input logic [1:0] d, input state_t st, input logic last,
                              input state_t exp, input int exp_lat, input string tag,
                              input bit pulse);
        int waited = 0;
        int lat = 0;
        while (!in_ready_s[d] && waited < 50) begin
            tick();
            waited++;
        end
        chk({tag, ".in_ready"}, 128'(in_ready_s[d]), 128'(1));
        din_s[d]      = st;
        in_last_s[d]  = last;
        in_valid_s[d] = 1'b1;
        exp_q.push_back(exp);
        tick();
        in_valid_s[d] = 1'b0;
        din_s[d]      = rnd_state();
        in_last_s[d]  = ~last;
        while (!out_valid_s[d] && lat < 20) begin
            if (pulse) in_valid_s[d] = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        in_valid_s[d] = 1'b0;
        chk({tag, ".latency"}, 128'(lat), 128'(exp_lat));
    endtask

    // Optionally stall for hold cycles, then pop and complete the handshake.
    task automatic recv_block(input logic [1:0] d, input int hold, input string tag);
        state_t exp;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 128'(out_valid_s[d]), 128'(0));
            return;
        end
        exp = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            in_valid_s[d] = 1'($urandom_range(0, 1));
            din_s[d]      = rnd_state();
            tick();
            chk({tag, ".hold_valid"}, 128'(out_valid_s[d]), 128'(1));
            chk({tag, ".hold_in_ready"}, 128'(in_ready_s[d]), 128'(0));
            chk({tag, ".hold_dout"}, dout_s[d], exp);
        end
        in_valid_s[d] = 1'b0;
        chk({tag, ".dout"}, dout_s[d], exp);
        out_ready_s[d] = 1'b1;
        tick();
        out_ready_s[d] = 1'b0;
        chk({tag, ".valid_fall"}, 128'(out_valid_s[d]), 128'(0));
        chk({tag, ".idle_ready"}, 128'(in_ready_s[d]), 128'(1));
        chk({tag, ".dout_held"}, dout_s[d], exp);
    endtask

    // Random traffic with random gaps, bypass flags and backpressure.
    task automatic stream(input logic [1:0] d, input int n, input string tag);
        int got = 0;
        fork
            begin : driver
                for (int k = 0; k < n; k++) begin
                    state_t st;
                    logic   last;
                    int     w;
                    st   = rnd_state();
                    last = ($urandom_range(0, 3) == 0);
                    repeat ($urandom_range(0, 2)) tick();
                    din_s[d]      = st;
                    in_last_s[d]  = last;
                    in_valid_s[d] = 1'b1;
                    w = 0;
                    while (!in_ready_s[d] && w < 200) begin
                        tick();
                        w++;
                    end
                    if (w >= 200) begin
                        chk({tag, ".accept_timeout"}, 128'(in_ready_s[d]), 128'(1));
                        in_valid_s[d] = 1'b0;
                        break;
                    end
                    exp_q.push_back(ref_mix(st, last));
                    tick();
                    in_valid_s[d] = 1'b0;
                    din_s[d]      = rnd_state();
                end
            end
            begin : monitor
                int cyc = 0;
                while (got < n && cyc < 6000) begin
                    out_ready_s[d] = 1'($urandom_range(0, 1));
                    if (out_valid_s[d] && out_ready_s[d]) begin
                        if (exp_q.size() == 0) begin
                            chk({tag, ".extra_out"}, 128'(out_valid_s[d]), 128'(0));
                        end else begin
                            chk({tag, ".dout"}, dout_s[d], exp_q.pop_front());
                        end
                        got++;
                    end
                    tick();
                    cyc++;
                end
                out_ready_s[d] = 1'b0;
            end
        join
        chk({tag, ".count"}, 128'(got), 128'(n));
        chk({tag, ".queue_left"}, 128'(exp_q.size()), 128'(0));
        // Nothing further may appear after the stream drains.
        out_ready_s[d] = 1'b1;
        repeat (12) begin
            tick();
            chk({tag, ".no_dup"}, 128'(out_valid_s[d]), 128'(0));
        end
        out_ready_s[d] = 1'b0;
        exp_q.delete();
    endtask

    state_t fips_cols_in, fips_cols_out, r1_in, r1_out;

    initial begin
        fips_cols_in  = mk_state(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
        fips_cols_out = mk_state(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
        r1_in         = mk_state(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
        r1_out        = mk_state(32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c);

        for (int i = 0; i < N_DUT; i++) begin
            rst_n_s[i]     = 1'b0;
            in_valid_s[i]  = 1'b0;
            in_last_s[i]   = 1'b0;
            out_ready_s[i] = 1'b0;
            din_s[i]       = '0;
        end
        tick();
        tick();
        for (int i = 0; i < N_DUT; i++) begin
            chk("reset.in_ready", 128'(in_ready_s[2'(i)]), 128'(1));
            chk("reset.out_valid", 128'(out_valid_s[2'(i)]), 128'(0));
            chk("reset.dout", dout_s[2'(i)], '0);
            rst_n_s[i] = 1'b1;
        end
        tick();

        // Known-answer vectors.
        send_block(2'd0, fips_cols_in, 1'b0, fips_cols_out, 5, "fips_cols_c1", 1'b0);
        recv_block(2'd0, 0, "fips_cols_c1");
        send_block(2'd0, r1_in, 1'b0, r1_out, 5, "round1_c1", 1'b0);
        recv_block(2'd0, 0, "round1_c1");
        send_block(2'd1, r1_in, 1'b0, r1_out, 3, "round1_c2", 1'b0);
        recv_block(2'd1, 0, "round1_c2");
        send_block(2'd2, r1_in, 1'b0, r1_out, 2, "round1_c4", 1'b0);
        recv_block(2'd2, 0, "round1_c4");

        // Final-round bypass.
        send_block(2'd0, r1_in, 1'b1, r1_in, 1, "bypass_c1", 1'b0);
        recv_block(2'd0, 0, "bypass_c1");
        send_block(2'd2, r1_in, 1'b1, r1_in, 1, "bypass_c4", 1'b0);
        recv_block(2'd2, 0, "bypass_c4");

        // Backpressure with ignored in_valid pulses, then a follow-up block.
        send_block(2'd0, r1_in, 1'b0, r1_out, 5, "bp_first", 1'b1);
        recv_block(2'd0, 10, "bp_first");
        send_block(2'd0, fips_cols_in, 1'b0, fips_cols_out, 5, "bp_second", 1'b0);
        recv_block(2'd0, 0, "bp_second");

        // Reset while BUSY at column 2.
        din_s[0]      = r1_in;
        in_last_s[0]  = 1'b0;
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        tick();
        tick();
        rst_n_s[0] = 1'b0;
        #1;
        chk("midrst.out_valid", 128'(out_valid_s[0]), 128'(0));
        chk("midrst.dout", dout_s[0], '0);
        chk("midrst.in_ready", 128'(in_ready_s[0]), 128'(1));
        tick();
        rst_n_s[0] = 1'b1;
        tick();
        send_block(2'd0, r1_in, 1'b0, r1_out, 5, "after_rst", 1'b0);
        recv_block(2'd0, 0, "after_rst");

        // Random streams against the reference model.
        stream(2'd0, 100, "stream_c1");
        stream(2'd1, 50, "stream_c2");
        stream(2'd2, 50, "stream_c4");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
